heartbeat_kicker: RTL and testbench

//  Transmit side of the watchdog heartbeat link: emits heartbeat pulses toward the

---
 rtl/wdg_pkg.sv | 15 +
 rtl/hb_pulse_gen.sv | 37 +++
 rtl/heartbeat_kicker.sv | 103 ++++++++++
 tb/tb_heartbeat_kicker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wdg_pkg.sv
// Shared types and defaults for the watchdog heartbeat kicker.
package wdg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        KICK,
        STALL
    } kick_state_e;

    localparam int unsigned DEF_NUM_TASKS = 4;
    localparam int unsigned DEF_CNT_W     = 10;
    localparam int unsigned DEF_PULSE_W   = 4;

endpackage

// File: rtl/hb_pulse_gen.sv
// Heartbeat pulse stretcher: a 1-cycle start gives PULSE_W cycles high, abortable.
module hb_pulse_gen #(
    parameter int unsigned PULSE_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic heartbeat,
    output logic last
);

    logic [3:0] remain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heartbeat <= 1'b0;
            remain    <= '0;
        end else if (abort) begin
            heartbeat <= 1'b0;
            remain    <= '0;
        end else if (start) begin
            heartbeat <= 1'b1;
            remain    <= 4'(PULSE_W - 1);
        end else if (heartbeat) begin
            if (remain == '0) begin
                heartbeat <= 1'b0;
            end else begin
                remain <= remain - 4'd1;
            end
        end
    end

    // Final high cycle of the pulse; the FSM leaves KICK on this cycle.
    assign last = heartbeat && (remain == '0);

endmodule

// File: rtl/heartbeat_kicker.sv
// Watchdog heartbeat transmitter: kicks once per interval while all supervised tasks check in.
module heartbeat_kicker
    import wdg_pkg::*;
#(
    parameter int unsigned NUM_TASKS = DEF_NUM_TASKS,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned PULSE_W   = DEF_PULSE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [CNT_W-1:0]     period,
    input  logic [NUM_TASKS-1:0] task_mask,
    input  logic [NUM_TASKS-1:0] checkin,
    input  logic                 clr_missed,
    output logic                 heartbeat,
    output logic                 stalled,
    output logic [NUM_TASKS-1:0] missed,
    output logic [15:0]          kick_count
);

    kick_state_e          state, state_nx;
    logic [CNT_W-1:0]     tick_cnt, last_tick;
    logic [NUM_TASKS-1:0] seen, seen_all, miss_bits;
    logic                 eval_pend, eval_hit, eval_now, pass;
    logic                 pulse_start, pulse_abort, pulse_last;

    assign last_tick = (period == '0) ? '0 : period - CNT_W'(1);
    assign eval_hit  = tick && (tick_cnt == last_tick);
    assign seen_all  = seen | checkin;
    assign pass      = (seen_all & task_mask) == task_mask;
    assign miss_bits = task_mask & ~seen_all;

    always_comb begin
        state_nx = state;
        eval_now = 1'b0;
        case (state)
            IDLE:    if (enable) state_nx = COLLECT;
            COLLECT: eval_now = eval_hit;
            KICK: begin
                // An interval that closed mid-pulse is evaluated on the pulse's last cycle.
                if (pulse_last) begin
                    eval_now = eval_pend || eval_hit;
                    state_nx = COLLECT;
                end
            end
            STALL:   state_nx = STALL;
            default: state_nx = IDLE;
        endcase
        if (eval_now) state_nx = pass ? KICK : STALL;
        if (!enable) begin
            state_nx = IDLE;
            eval_now = 1'b0;
        end
    end

    assign pulse_start = eval_now && pass;
    assign pulse_abort = !enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            seen       <= '0;
            eval_pend  <= 1'b0;
            stalled    <= 1'b0;
            missed     <= '0;
            kick_count <= '0;
        end else begin
            state  <= state_nx;
            missed <= (clr_missed ? '0 : missed) | ((eval_now && !pass) ? miss_bits : '0);
            if (!enable || state == IDLE) begin
                tick_cnt  <= '0;
                seen      <= '0;
                eval_pend <= 1'b0;
                if (!enable) stalled <= 1'b0;
            end else if (eval_now) begin
                tick_cnt  <= '0;
                seen      <= '0;
                eval_pend <= 1'b0;
                if (pass) kick_count <= kick_count + 16'd1;
                else      stalled    <= 1'b1;
            end else if (state == COLLECT || state == KICK) begin
                seen <= seen_all;
                if (eval_hit)                eval_pend <= 1'b1;
                else if (tick && !eval_pend) tick_cnt  <= tick_cnt + CNT_W'(1);
            end
        end
    end

    hb_pulse_gen #(
        .PULSE_W(PULSE_W)
    ) u_pulse (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (pulse_start),
        .abort     (pulse_abort),
        .heartbeat (heartbeat),
        .last      (pulse_last)
    );

endmodule

// File: tb/tb_heartbeat_kicker.sv
// Directed and randomized checks of heartbeat_kicker against an interval-level reference model.
module tb_heartbeat_kicker;

    localparam int unsigned NT      = 4;
    localparam int unsigned CW      = 10;
    localparam int unsigned PW      = 4;
    localparam int          WD_LIMIT = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          tick;
    logic [CW-1:0] period;
    logic [NT-1:0] task_mask;
    logic [NT-1:0] checkin;
    logic          clr_missed;
    logic          heartbeat;
    logic          stalled;
    logic [NT-1:0] missed;
    logic [15:0]   kick_count;

    int tests = 0;
    int fails = 0;
    int hb_cycles = 0;
    int wd_idle = 0;

    // reference model state
    bit          m_on, m_stall, m_held;
    int          m_hb_rem, m_ticks;
    bit [NT-1:0] m_seen, m_missed;
    bit [15:0]   m_kc;

    heartbeat_kicker #(
        .NUM_TASKS(NT),
        .CNT_W    (CW),
        .PULSE_W  (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .tick       (tick),
        .period     (period),
        .task_mask  (task_mask),
        .checkin    (checkin),
        .clr_missed (clr_missed),
        .heartbeat  (heartbeat),
        .stalled    (stalled),
        .missed     (missed),
        .kick_count (kick_count)
    );

    always #5 clk = ~clk;

    // Simple watchdog: times out when no heartbeat is seen for WD_LIMIT cycles.
    always @(posedge clk) begin
        if (heartbeat) wd_idle <= 0;
        else           wd_idle <= wd_idle + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_stall = 0; m_held = 0;
        m_hb_rem = 0; m_ticks = 0;
        m_seen = '0; m_missed = '0; m_kc = '0;
    endtask

    task automatic model_step();
        bit [NT-1:0] setb, got;
        int          plen;
        bit          boundary, closing;
        setb = '0;
        if (!enable) begin
            m_on = 0; m_stall = 0; m_held = 0;
            m_hb_rem = 0; m_ticks = 0; m_seen = '0;
        end else if (!m_on) begin
            m_on = 1; m_held = 0; m_ticks = 0; m_seen = '0;
        end else if (!m_stall) begin
            plen     = (period == 0) ? 1 : int'(period);
            boundary = tick && (m_ticks == plen - 1);
            closing  = (m_hb_rem <= 1) && (m_held || boundary);
            got      = m_seen | checkin;
            if (m_hb_rem > 0) m_hb_rem--;
            if (closing) begin
                m_held = 0; m_ticks = 0; m_seen = '0;
                if ((got & task_mask) == task_mask) begin
                    m_kc++;
                    m_hb_rem = PW;
                end else begin
                    setb    = task_mask & ~got;
                    m_stall = 1;
                end
            end else begin
                m_seen = got;
                if (boundary)              m_held = 1;
                else if (tick && !m_held)  m_ticks++;
            end
        end
        m_missed = (clr_missed ? '0 : m_missed) | setb;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        hb_cycles += int'(heartbeat);
        check("heartbeat",  32'(heartbeat),  32'(m_hb_rem > 0));
        check("stalled",    32'(stalled),    32'(m_stall));
        check("missed",     32'(missed),     32'(m_missed));
        check("kick_count", 32'(kick_count), 32'(m_kc));
        tick = 1'b0; checkin = '0; clr_missed = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n, input int gap, input logic [NT-1:0] ci_mid,
                             input logic [NT-1:0] ci_tick, input logic clr_tick);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < gap - 1; j++) begin
                if (j == 1) checkin = ci_mid;
                cycle();
            end
            tick = 1'b1; checkin = ci_tick; clr_missed = clr_tick;
            cycle();
        end
    endtask

    initial begin
        int kc0, hb0;
        rst_n = 1'b0; enable = 1'b0; tick = 1'b0; period = '0;
        task_mask = '0; checkin = '0; clr_missed = 1'b0;
        model_reset();
        #12;
        check("rst_heartbeat",  32'(heartbeat),  32'd0);
        check("rst_stalled",    32'(stalled),    32'd0);
        check("rst_missed",     32'(missed),     32'd0);
        check("rst_kick_count", 32'(kick_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // basic: period 3, two supervised tasks always checking in
        period = 10'd3; task_mask = 4'b0011; enable = 1'b1;
        cycle();
        hb0 = hb_cycles;
        run_ticks(9, 6, 4'b0011, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) cycle();
        check("basic_kicks", 32'(kick_count), 32'd3);
        check("basic_hb_width", 32'(hb_cycles - hb0), 32'd12);
        check("basic_wd_alive", 32'(wd_idle > WD_LIMIT), 32'd0);

        // miss: task1 silent for a whole interval
        run_ticks(3, 6, 4'b0001, 4'b0000, 1'b0);
        check("miss_stalled", 32'(stalled), 32'd1);
        check("miss_missed",  32'(missed),  32'h2);
        hb0 = hb_cycles;
        run_ticks(6, 6, 4'b0011, 4'b0000, 1'b0);
        check("miss_no_hb",     32'(hb_cycles - hb0), 32'd0);
        check("miss_wd_timeout", 32'(wd_idle > WD_LIMIT), 32'd1);

        // recover: drop enable for one cycle
        enable = 1'b0; cycle();
        check("rec_stalled", 32'(stalled), 32'd0);
        check("rec_missed",  32'(missed),  32'h2);
        enable = 1'b1; cycle();
        clr_missed = 1'b1; cycle();
        check("rec_clr", 32'(missed), 32'd0);
        run_ticks(2, 6, 4'b0001, 4'b0000, 1'b0);
        run_ticks(1, 6, 4'b0001, 4'b0000, 1'b1);
        check("set_beats_clr", 32'(missed), 32'h2);
        enable = 1'b0; cycle();
        clr_missed = 1'b1; cycle();

        // edge check-in on the evaluation cycle, then one cycle after
        enable = 1'b1; cycle();
        kc0 = int'(kick_count);
        run_ticks(2, 6, 4'b0010, 4'b0000, 1'b0);
        run_ticks(1, 6, 4'b0010, 4'b0001, 1'b0);
        check("edge_hb_rise", 32'(heartbeat), 32'd1);
        check("edge_kick",    32'(kick_count), 32'(kc0 + 1));
        checkin = 4'b0011; cycle();
        run_ticks(3, 6, 4'b0000, 4'b0000, 1'b0);
        check("edge_next_interval", 32'(kick_count), 32'(kc0 + 2));
        run_ticks(3, 6, 4'b0000, 4'b0000, 1'b0);
        check("edge_not_carried", 32'(missed), 32'h3);
        enable = 1'b0; cycle();
        clr_missed = 1'b1; cycle();

        // corners: period 0, mask 0, kick_count wrap
        period = '0; enable = 1'b1; cycle();
        kc0 = int'(kick_count);
        run_ticks(4, 6, 4'b0000, 4'b0011, 1'b0);
        check("period0_kicks", 32'(kick_count), 32'(kc0 + 4));
        task_mask = '0;
        run_ticks(4, 6, 4'b0000, 4'b0000, 1'b0);
        check("mask0_kicks", 32'(kick_count), 32'(kc0 + 8));
        enable = 1'b0; cycle();
        force dut.kick_count = 16'hFFFE;
        #1;
        release dut.kick_count;
        m_kc = 16'hFFFE;
        enable = 1'b1; cycle();
        run_ticks(2, 6, 4'b0000, 4'b0000, 1'b0);
        check("kc_wrap", 32'(kick_count), 32'h0);
        run_ticks(1, 6, 4'b0000, 4'b0000, 1'b0);
        check("kc_after_wrap", 32'(kick_count), 32'h1);
        enable = 1'b0; cycle();

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            if (!enable || $urandom_range(0, 39) == 0) begin
                enable    = (enable == 1'b0);
                period    = CW'($urandom_range(0, 4));
                task_mask = NT'($urandom_range(0, 15));
            end
            tick       = ($urandom_range(0, 2) == 0);
            checkin    = NT'($urandom_range(0, 15));
            clr_missed = ($urandom_range(0, 24) == 0);
            cycle();
        end

        // abort: enable drop mid-pulse, then reset mid-pulse
        enable = 1'b0; cycle();
        period = 10'd1; task_mask = '0; enable = 1'b1; cycle();
        tick = 1'b1; cycle();
        check("abort_hb_up", 32'(heartbeat), 32'd1);
        cycle();
        enable = 1'b0; cycle();
        check("abort_enable", 32'(heartbeat), 32'd0);
        enable = 1'b1; cycle();
        tick = 1'b1; cycle();
        cycle();
        check("abort_hb_up2", 32'(heartbeat), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hb",      32'(heartbeat),  32'd0);
        check("async_rst_stalled", 32'(stalled),    32'd0);
        check("async_rst_missed",  32'(missed),     32'd0);
        check("async_rst_kc",      32'(kick_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
